// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_pkg
//  Purpose  : Shared types for the LED pattern sequencer: mode codes, FSM
//             state encoding, bounce direction and counter sizing helper.
//  Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    // Requested / applied LED pattern mode (matches the 2-bit mode_in code).
    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    // Mode-change handshake state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    // Bounce travel direction: left means toward the MSB.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Width of a counter holding 0..div-1, never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/tick_rise_det.sv
`default_nettype none
// ============================================================================
//  Module   : tick_rise_det
//  Purpose  : Registers the divider output and emits a registered one-cycle
//             pulse for every low-to-high transition. A level held high for
//             many cycles produces a single pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic rise
);

    logic r_tick_d;

    // Delay the tick level by one clock and flag the cycle it first goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            r_tick_d <= tick;
            rise     <= tick & ~r_tick_d;
        end
    end

endmodule : tick_rise_det
`default_nettype wire

// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_seq
//  Purpose  : Drives an LED bank with OFF / BLINK / CHASE / BOUNCE patterns,
//             advancing one step every STEP_DIV rising edges of the divider
//             tick. Mode changes are handshaked (mode_wr / mode_busy) and are
//             applied on a step boundary.
//  Options  : LED_PWM_EN - adds the bright input and a free-running PWM
//             counter that gates the LED outputs.
//  Revision : 1.0 - initial release
// ============================================================================
import led_seq_pkg::*;

module led_pattern_seq #(
    parameter int N_LEDS   = 8,
    parameter int STEP_DIV = 4,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                en,
    input  logic [1:0]          mode_in,
    input  logic                mode_wr,
`ifdef LED_PWM_EN
    input  logic [PWM_BITS-1:0] bright,
`endif
    output logic                mode_busy,
    output logic [1:0]          cur_mode,
    output logic                step_pulse,
    output logic [N_LEDS-1:0]   led
);

    localparam int                 c_cnt_w    = cnt_width(STEP_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STEP_DIV - 1);

    logic                w_rise;
    logic                w_step;
    logic                w_cnt_clear;
    logic [c_cnt_w-1:0]  r_step_cnt;

    state_t              r_state,     w_state_nxt;
    mode_t               r_cur_mode,  w_cur_mode_nxt;
    mode_t               r_pend_mode, w_pend_mode_nxt;
    dir_t                r_dir,       w_dir_nxt;
    dir_t                w_adv_dir;
    logic                r_busy,      w_busy_nxt;
    logic [N_LEDS-1:0]   r_pattern,   w_pattern_nxt;
    logic [N_LEDS-1:0]   w_adv_pattern;
    logic [N_LEDS-1:0]   w_led_nxt;
    logic                r_step_pulse;
    logic [N_LEDS-1:0]   r_led;
    mode_t               w_mode_req;

    assign w_mode_req = mode_t'(mode_in);

    // Starting pattern loaded whenever a mode is applied.
    function automatic logic [N_LEDS-1:0] init_pattern(input mode_t m);
        case (m)
            MODE_BLINK:              return '1;
            MODE_CHASE, MODE_BOUNCE: return N_LEDS'(1);
            default:                 return '0;
        endcase
    endfunction

    tick_rise_det u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .rise  (w_rise)
    );

    // A step is the STEP_DIV-th accepted rise; en=0 discards rises entirely.
    assign w_step = w_rise & en & (r_step_cnt == c_cnt_last);

    // Divider-edge counter; cleared when a mode is applied from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_cnt <= '0;
        end else if (w_cnt_clear) begin
            r_step_cnt <= '0;
        end else if (w_rise && en) begin
            r_step_cnt <= (r_step_cnt == c_cnt_last) ? '0 : r_step_cnt + 1'b1;
        end
    end

    // Next pattern and direction if the current mode advances by one step.
    always_comb begin
        w_adv_pattern = r_pattern;
        w_adv_dir     = r_dir;
        case (r_cur_mode)
            MODE_BLINK: w_adv_pattern = ~r_pattern;
            MODE_CHASE: w_adv_pattern = (r_pattern << 1) | (r_pattern >> (N_LEDS - 1));
            MODE_BOUNCE: begin
                // A single LED has nowhere to travel, so it stays lit.
                if (N_LEDS > 1) begin
                    if (r_dir == DIR_LEFT) begin
                        w_adv_pattern = r_pattern << 1;
                        if (w_adv_pattern[N_LEDS-1]) w_adv_dir = DIR_RIGHT;
                    end else begin
                        w_adv_pattern = r_pattern >> 1;
                        if (w_adv_pattern[0]) w_adv_dir = DIR_LEFT;
                    end
                end
            end
            default: w_adv_pattern = '0;
        endcase
    end

    // Mode handshake FSM: applies writes from IDLE at once, defers them to the
    // next step boundary while running.
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_mode_nxt  = r_cur_mode;
        w_pend_mode_nxt = r_pend_mode;
        w_dir_nxt       = r_dir;
        w_busy_nxt      = r_busy;
        w_pattern_nxt   = r_pattern;
        w_cnt_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mode_wr && (w_mode_req != MODE_OFF)) begin
                    w_cur_mode_nxt = w_mode_req;
                    w_pattern_nxt  = init_pattern(w_mode_req);
                    w_dir_nxt      = DIR_LEFT;
                    w_cnt_clear    = 1'b1;
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_step) begin
                    w_pattern_nxt = w_adv_pattern;
                    w_dir_nxt     = w_adv_dir;
                end
                // A write on a step cycle still lets the old mode take that step.
                if (mode_wr) begin
                    w_pend_mode_nxt = w_mode_req;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_step) begin
                    w_cur_mode_nxt = r_pend_mode;
                    w_pattern_nxt  = init_pattern(r_pend_mode);
                    w_dir_nxt      = DIR_LEFT;
                    w_busy_nxt     = 1'b0;
                    w_state_nxt    = (r_pend_mode == MODE_OFF) ? ST_IDLE : ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_mode   <= MODE_OFF;
            r_pend_mode  <= MODE_OFF;
            r_dir        <= DIR_LEFT;
            r_busy       <= 1'b0;
            r_pattern    <= '0;
            r_step_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_mode   <= w_cur_mode_nxt;
            r_pend_mode  <= w_pend_mode_nxt;
            r_dir        <= w_dir_nxt;
            r_busy       <= w_busy_nxt;
            r_pattern    <= w_pattern_nxt;
            r_step_pulse <= w_step;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;

    // Free-running brightness counter; keeps running while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_led_nxt = w_pattern_nxt & {N_LEDS{r_pwm_cnt < bright}};
`else
    assign w_led_nxt = w_pattern_nxt;

    // PWM_BITS only sizes the brightness path, which is compiled out here.
    if (PWM_BITS < 1) begin : g_pwm_cfg_unused
        logic unused_pwm_cfg;
        assign unused_pwm_cfg = 1'b0;
    end
`endif

    // LED drive register, updated in the same cycle as the pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign led        = r_led;
    assign cur_mode   = r_cur_mode;
    assign mode_busy  = r_busy;
    assign step_pulse = r_step_pulse;

endmodule : led_pattern_seq
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_seq
//  Purpose  : Bench for led_pattern_seq. Two instances share clock, reset,
//             tick and en: A (8 LEDs, 4 rises per step) and B (4 LEDs, every
//             rise a step). A spec-level model tracks LED position / phase
//             per instance and is compared every cycle; directed checks pin
//             the model with hand-computed values.
//  Options  : LED_PWM_EN - connects bright and checks the LED duty cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_seq;

    localparam int c_pwm_bits = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       en = 1'b1;
    logic [1:0] mode_in_a = 2'd0, mode_in_b = 2'd0;
    logic       mode_wr_a = 1'b0, mode_wr_b = 1'b0;
    logic [c_pwm_bits-1:0] bright = 4'd4;

    logic       busy_a, busy_b, sp_a, sp_b;
    logic [1:0] cm_a, cm_b;
    logic [7:0] led_a;
    logic [3:0] led_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(.N_LEDS(8), .STEP_DIV(4), .PWM_BITS(c_pwm_bits)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
        .mode_in(mode_in_a), .mode_wr(mode_wr_a),
`ifdef LED_PWM_EN
        .bright(bright),
`endif
        .mode_busy(busy_a), .cur_mode(cm_a), .step_pulse(sp_a), .led(led_a)
    );

    led_pattern_seq #(.N_LEDS(4), .STEP_DIV(1), .PWM_BITS(c_pwm_bits)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
        .mode_in(mode_in_b), .mode_wr(mode_wr_b),
`ifdef LED_PWM_EN
        .bright(bright),
`endif
        .mode_busy(busy_b), .cur_mode(cm_b), .step_pulse(sp_b), .led(led_b)
    );

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 running, 2 change pending. pos = index of the lit LED.
    typedef struct packed {
        bit tick_prev;
        bit rise_q;
        int cnt;
        int st;
        int mode;
        int pmode;
        int pos;
        bit left;
        bit phase;
        bit busy;
        bit sp;
        int led;
        int pwm;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t r;
        r = '0;
        r.left = 1'b1;
        return r;
    endfunction

    function automatic mdl_t mapply(mdl_t m, int md);
        mdl_t r;
        r = m;
        r.mode  = md;
        r.pos   = 0;
        r.left  = 1'b1;
        r.phase = 1'b1;
        return r;
    endfunction

    function automatic mdl_t madvance(mdl_t m, int n);
        mdl_t r;
        r = m;
        case (m.mode)
            1: r.phase = ~m.phase;
            2: r.pos = (m.pos + 1) % n;
            3: if (n > 1) begin
                if (m.left) begin
                    r.pos = m.pos + 1;
                    if (r.pos == n - 1) r.left = 1'b0;
                end else begin
                    r.pos = m.pos - 1;
                    if (r.pos == 0) r.left = 1'b1;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic int mpattern(mdl_t m, int n);
        case (m.mode)
            1:       return m.phase ? (1 << n) - 1 : 0;
            2, 3:    return 1 << m.pos;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit tk, bit e, int mi, bit wr,
                                   int n, int sd, int br);
        mdl_t r;
        bit   step;
        r    = m;
        step = m.rise_q && e && (m.cnt == sd - 1);
        r.rise_q    = tk && !m.tick_prev;
        r.tick_prev = tk;
        if (m.rise_q && e) r.cnt = step ? 0 : m.cnt + 1;
        r.sp = step;
        case (m.st)
            0: if (wr && mi != 0) begin
                r = mapply(r, mi);
                r.cnt = 0;
                r.st = 1;
            end
            1: begin
                if (step) r = madvance(r, n);
                if (wr) begin
                    r.pmode = mi;
                    r.busy = 1'b1;
                    r.st = 2;
                end
            end
            default: if (step) begin
                r = mapply(r, m.pmode);
                r.busy = 1'b0;
                r.st = (m.pmode == 0) ? 0 : 1;
            end
        endcase
        r.led = mpattern(r, n);
`ifdef LED_PWM_EN
        if (!(m.pwm < br)) r.led = 0;
        r.pwm = (m.pwm + 1) % (1 << c_pwm_bits);
`else
        r.pwm = br & 0;
`endif
        return r;
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, tick, en, int'(mode_in_a), mode_wr_a, 8, 4, int'(bright));
            mb <= mstep(mb, tick, en, int'(mode_in_b), mode_wr_b, 4, 1, int'(bright));
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle out of reset, all outputs of both instances track the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_led",  int'(led_a),  ma.led);
            chk("a_mode", int'(cm_a),   ma.mode);
            chk("a_busy", int'(busy_a), int'(ma.busy));
            chk("a_step", int'(sp_a),   int'(ma.sp));
            chk("b_led",  int'(led_b),  mb.led);
            chk("b_mode", int'(cm_b),   mb.mode);
            chk("b_busy", int'(busy_b), int'(mb.busy));
            chk("b_step", int'(sp_b),   int'(mb.sp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic rise_tick(input int hi);
        @(negedge clk) tick = 1'b1;
        repeat (hi) @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_modes(input int am, input bit aw, input int bm, input bit bw);
        @(negedge clk);
        mode_in_a = 2'(am); mode_wr_a = aw;
        mode_in_b = 2'(bm); mode_wr_b = bw;
        @(negedge clk);
        mode_wr_a = 1'b0; mode_wr_b = 1'b0;
    endtask

    int bounce_exp [8] = '{2, 4, 8, 4, 2, 1, 2, 4};
`ifdef LED_PWM_EN
    int on_cnt;
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_led_a", int'(led_a), 0);
        chk("rst_mode_a", int'(cm_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_step_a", int'(sp_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A -> CHASE, B -> BOUNCE
        write_modes(2, 1'b1, 3, 1'b1);
        chk("chase_init", int'(led_a), 'h01);
        chk("chase_mode", int'(cm_a), 2);
        chk("bounce_init", int'(led_b), 'h1);

        // Step latency: edge k samples tick, edge k+1 raises step_pulse (rise 1 steps B).
        @(negedge clk) tick = 1'b1;
        @(negedge clk);
        chk("lat_k", int'(sp_b), 0);
        tick = 1'b0;
        @(negedge clk);
        chk("lat_k1", int'(sp_b), 1);
        chk("bounce_1", int'(led_b), bounce_exp[0]);
        for (int i = 1; i < 8; i++) begin
            rise_tick(1);
            chk("bounce_seq", int'(led_b), bounce_exp[i]);
            if (i == 3) begin
                chk("chase_r4", int'(led_a), 'h02);
                chk("chase_r4_sp", int'(sp_a), 1);
            end
            if (i == 6) chk("chase_r7_sp", int'(sp_a), 0);
        end
        chk("chase_r8", int'(led_a), 'h04);

        // Walk A to the top LED, then wrap.
        repeat (20) rise_tick(1);
        chk("chase_top", int'(led_a), 'h80);
        repeat (4) rise_tick(1);
        chk("chase_wrap", int'(led_a), 'h01);

        // Deferred mode change CHASE -> BLINK.
        write_modes(1, 1'b1, 0, 1'b0);
        chk("pend_busy", int'(busy_a), 1);
        chk("pend_oldmode", int'(cm_a), 2);
        repeat (4) rise_tick(1);
        chk("blink_init", int'(led_a), 'hFF);
        chk("blink_mode", int'(cm_a), 1);
        chk("blink_busy", int'(busy_a), 0);
        repeat (4) rise_tick(1);
        chk("blink_inv", int'(led_a), 'h00);

        // BLINK -> CHASE; a second write while busy must be dropped.
        write_modes(2, 1'b1, 0, 1'b0);
        write_modes(3, 1'b1, 0, 1'b0);
        chk("busy_hold", int'(busy_a), 1);
        repeat (3) rise_tick(1);
        chk("busy_still", int'(busy_a), 1);
        rise_tick(1);
        chk("chg_led", int'(led_a), 'h01);
        chk("chg_mode", int'(cm_a), 2);
        chk("chg_busy", int'(busy_a), 0);

        // Long-held tick counts once; en=0 drops rises.
        rise_tick(20);
        @(negedge clk) en = 1'b0;
        repeat (3) rise_tick(1);
        chk("en0_led", int'(led_a), 'h01);
        en = 1'b1;
        repeat (2) rise_tick(1);
        chk("en1_hold", int'(led_a), 'h01);
        rise_tick(1);
        chk("en1_step", int'(led_a), 'h02);

        // Async reset in the middle of a pending change.
        write_modes(3, 1'b1, 0, 1'b0);
        chk("pre_rst_busy", int'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", int'(led_a), 0);
        chk("arst_mode", int'(cm_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        @(negedge clk) rst_n = 1'b1;
        write_modes(0, 1'b1, 0, 1'b0);
        chk("off_noop", int'(cm_a), 0);
        rise_tick(1);
        chk("lost_pend", int'(cm_a), 0);

`ifdef LED_PWM_EN
        write_modes(1, 1'b1, 0, 1'b0);
        @(negedge clk) en = 1'b0;
        on_cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (led_a[0]) on_cnt = on_cnt + 1;
        end
        chk("pwm_duty", on_cnt, 4);
        en = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_pattern_seq
`default_nettype wire

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Consumes the divided clock from the team's clock-divider stage and drives an LED bank with selectable patterns: off, blink, chase, bounce. Detects rising edges of the divider output in the `clk` domain and advances the pattern every STEP_DIV edges. Mode changes use a write/busy handshake and take effect only at a step boundary. Sits between the clock divider and the board LED pins.

Parameters:
N_LEDS, 8, number of LED outputs (>=1)
STEP_DIV, 4, divider rising edges per pattern step (>=1)
PWM_BITS, 4, brightness resolution; used only with LED_PWM_EN

Ports:
clk  input  1  system clock; same clock that drives the divider
rst_n  input  1  asynchronous, active-low reset
tick  input  1  divider output; synchronous to clk; level signal, rising edge used
en  input  1  1 = run; 0 = freeze counters, pattern and LEDs
mode_in  input  2  requested mode: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE
mode_wr  input  1  one-cycle write strobe for mode_in
mode_busy  output  1  high while a mode change is pending; mode_wr is ignored while high
cur_mode  output  2  currently applied mode
step_pulse  output  1  one-cycle pulse on each pattern step
led  output  N_LEDS  LED drive, registered

Behaviour:
- Reset (rst_n=0, async): led=0, cur_mode=OFF, step_pulse=0, mode_busy=0, step_cnt=0, tick_d=0, dir=left, FSM=IDLE, pending mode=OFF.
- Edge detect: tick_d<=tick every clk. tick_rise = tick & ~tick_d. A tick held high for many cycles counts once.
- Step counter: width clog2(STEP_DIV), min 1. On tick_rise with en=1: if step_cnt==STEP_DIV-1 then step_cnt<=0 and this is a step; else step_cnt+1. With STEP_DIV=1, every rise is a step.
- Latency: tick first sampled high at edge k. step_pulse and led update at edge k+1 (one clk).
- step_pulse is registered, high for exactly one cycle per step, and asserts in every mode including OFF.
- en=0: tick_rise is ignored, step_cnt/pattern/dir/led hold, and tick_d still tracks tick. A pending mode change stays pending.
- FSM states and transitions:
  - IDLE (cur_mode=OFF): mode_wr with mode_in!=OFF applies the mode on the next edge: load its initial pattern, reset step_cnt, go to RUN. mode_wr with OFF is a no-op.
  - RUN: mode_wr latches mode_in, sets mode_busy=1 on the next edge, and goes to PENDING.
  - PENDING: on the next step, apply the pending mode instead of advancing the current one. Load its initial pattern, clear mode_busy, and go to RUN (or IDLE if the new mode is OFF).
- Simultaneous mode_wr and step in RUN: the step advances the old pattern; the write goes to PENDING and applies at the following step.
- Initial patterns: BLINK all ones; CHASE 1 (LSB); BOUNCE 1 with dir=left; OFF all zeros.
- Advance rules per step:
  - BLINK: invert all bits.
  - CHASE: rotate left; bit N-1 wraps to bit 0.
  - BOUNCE: shift toward dir. When the set bit reaches bit N-1 (left) or bit 0 (right), dir reverses on the same edge, so each end LED lights for one step only. N_LEDS=1: pattern stays 1.
  - OFF: pattern stays 0.
- Reset mid-operation returns immediately to the reset values, and a pending mode change is lost.

Optional Feature:
LED_PWM_EN defined:
- Adds input port bright [PWM_BITS-1:0] and a free-running PWM_BITS-wide pwm_cnt on clk (reset 0, wraps; not gated by en).
- led <= pattern & {N_LEDS{pwm_cnt < bright}}, registered, so duty = bright/2^PWM_BITS.
- bright=0 forces the LEDs off.

LED_PWM_EN undefined:
- No bright port and no pwm_cnt; led <= pattern.

Decomposition:
- Package led_seq_pkg: mode constants MODE_OFF/BLINK/CHASE/BOUNCE (2-bit), FSM state encoding ST_IDLE/ST_RUN/ST_PENDING, direction constants.
- One sub-module, tick_rise_det: registers tick, outputs a one-cycle rise pulse, async active-low reset.

Test Plan:
- Reset then mode_wr=CHASE, N_LEDS=8, STEP_DIV=4, 8 tick rises -> led 0x01 after write, 0x02 at the 4th rise, 0x04 at the 8th; one step_pulse per 4 rises, each 1 clk after tick first sampled high.
- CHASE wrap: from led=0x80, one step -> led=0x01.
- BOUNCE, N_LEDS=4, STEP_DIV=1, 8 steps -> 1,2,4,8,4,2,1,2,4.
- Mode change: RUN BLINK, mode_wr=CHASE between steps -> mode_busy=1 until the next step; at that step led=0x01, cur_mode=2, mode_busy=0. A second mode_wr while busy is ignored.
- tick held high 20 cycles, and en=0 across 3 rises -> each case counts at most one rise; led and step_cnt unchanged while en=0; resumes correctly after en=1.
- Async reset asserted mid-PENDING, between clk edges -> led=0, cur_mode=0, mode_busy=0 immediately. With LED_PWM_EN, PWM_BITS=4, bright=4 -> led high 4 of every 16 clks.
